// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state encoding
// and default geometry constants.
package fifo_uart_pkg;

   localparam int unsigned DEFAULT_DATA_W       = 8;
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each serial bit. Held at zero while clear is high.
module uart_baud_cnt #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (bit_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign bit_end = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte per frame and sends it as
// start / LSB-first data / [parity] / stop. Optional even parity bit is
// enabled by defining FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned DATA_W       = DEFAULT_DATA_W,
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd_en,
   output logic              tx,
   output logic              busy,
   output logic              byte_done
);

   localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   state_t            state, state_n;
   logic [DATA_W-1:0] shift, shift_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic              tx_n;
   logic              bit_end;
   logic              baud_clear;
`ifdef FIFO_UART_TX_PARITY_EN
   logic              parity_q;
`endif

   // Baud timer only runs while a bit is on the line.
   assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clear   (baud_clear),
      .bit_end (bit_end)
   );

   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_n = state;
      shift_n = shift;
      idx_n   = idx;
      case (state)
         IDLE:  if (tx_en && !fifo_empty) state_n = FETCH;
         FETCH: state_n = LOAD;
         LOAD: begin
            shift_n = fifo_data;
            state_n = START;
         end
         START: if (bit_end) state_n = DATA;
         DATA: begin
            if (bit_end) begin
               shift_n = shift >> 1;
               if (idx == LAST_IDX) begin
                  idx_n = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: if (bit_end) state_n = STOP;
`endif
         STOP:  if (bit_end) state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // Line level is derived from the upcoming state so tx comes straight off a flop.
      tx_n = 1'b1;
      case (state_n)
         START: tx_n = 1'b0;
         DATA:  tx_n = shift_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: tx_n = parity_q;
`endif
         default: tx_n = 1'b1;
      endcase
   end

   // NOTE: the shift register is a plain register, not a memory, so it is
   // reset along with the FSM to keep reset state fully defined.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shift      <= '0;
         idx        <= '0;
         tx         <= 1'b1;
         fifo_rd_en <= 1'b0;
         busy       <= 1'b0;
         byte_done  <= 1'b0;
      end else begin
         state      <= state_n;
         shift      <= shift_n;
         idx        <= idx_n;
         tx         <= tx_n;
         fifo_rd_en <= (state_n == FETCH);
         busy       <= (state_n != IDLE);
         byte_done  <= (state == STOP) && (state_n == IDLE);
      end
   end

`ifdef FIFO_UART_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else if (state == LOAD) begin
         parity_q <= ^fifo_data;
      end
   end
`endif

endmodule
